// File: rtl/gb_reg_file_multi_if.sv
// Decoder/sequencer-side bundle for gb_reg_file_multi: byte/pair read selects, write ports, IDU controls.
// Purely combinational signal grouping. There is no handshake; every request completes in the cycle it is presented.
interface gb_reg_file_multi_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2
);
  localparam int SEL_W  = $clog2(NUM_REGS);
  localparam int PSEL_W = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1;

  logic [NUM_RD*SEL_W-1:0]  i_rd_sel;
  logic [NUM_RD*DATA_W-1:0] o_rd_data;
  logic [PSEL_W-1:0]        i_rdp_sel;
  logic [2*DATA_W-1:0]      o_rdp_data;
  logic                     i_wr_en;
  logic [SEL_W-1:0]         i_wr_sel;
  logic [DATA_W-1:0]        i_wr_data;
  logic                     i_wrp_en;
  logic [PSEL_W-1:0]        i_wrp_sel;
  logic [2*DATA_W-1:0]      i_wrp_data;
  logic                     i_idu_en;
  logic                     i_idu_dec;
  logic [PSEL_W-1:0]        i_idu_sel;
  logic [2*DATA_W-1:0]      o_idu_result;
  logic [3:0]               o_flags;

  modport master (
    output i_rd_sel, i_rdp_sel, i_wr_en, i_wr_sel, i_wr_data,
           i_wrp_en, i_wrp_sel, i_wrp_data, i_idu_en, i_idu_dec, i_idu_sel,
    input  o_rd_data, o_rdp_data, o_idu_result, o_flags
  );

  modport slave (
    input  i_rd_sel, i_rdp_sel, i_wr_en, i_wr_sel, i_wr_data,
           i_wrp_en, i_wrp_sel, i_wrp_data, i_idu_en, i_idu_dec, i_idu_sel,
    output o_rd_data, o_rdp_data, o_idu_result, o_flags
  );
endinterface

// File: rtl/gb_reg_file_multi.sv
// CPU GPR file with byte/pair ports and pair INC/DEC unit; 0-cycle reads, 1-cycle writes, never stalls.
// Optional REG_FILE_BYPASS_EN forwards this cycle's write data (same byte priority) to all read ports and o_flags.
module gb_reg_file_multi #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int FLAG_IDX = 7
) (
  input logic                i_clk,
  input logic                i_rst_n,
  gb_reg_file_multi_if.slave rf
);
  localparam int SEL_W     = $clog2(NUM_REGS);
  localparam int PSEL_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1;
  localparam int NUM_PAIRS = NUM_REGS / 2;
  localparam int PAIR_W    = 2 * DATA_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] view   [NUM_REGS];
  logic [PAIR_W-1:0] idu_pair;
  logic [PAIR_W-1:0] idu_result;

  // IDU operand is always the pre-edge pair; an out-of-range select sees 0.
  always_comb begin
    idu_pair = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (rf.i_idu_sel == PSEL_W'(p)) idu_pair = {regs_q[2*p], regs_q[2*p+1]};
    end
    idu_result = rf.i_idu_dec ? (idu_pair - PAIR_W'(1)) : (idu_pair + PAIR_W'(1));
  end

  // Per-byte merge, lowest priority first so later assignments win: IDU < pair write < byte write.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (rf.i_idu_en && (rf.i_idu_sel == PSEL_W'(r / 2))) begin
        regs_d[r] = ((r % 2) == 0) ? idu_result[PAIR_W-1:DATA_W] : idu_result[DATA_W-1:0];
      end
      if (rf.i_wrp_en && (rf.i_wrp_sel == PSEL_W'(r / 2))) begin
        regs_d[r] = ((r % 2) == 0) ? rf.i_wrp_data[PAIR_W-1:DATA_W] : rf.i_wrp_data[DATA_W-1:0];
      end
      if (rf.i_wr_en && (rf.i_wr_sel == SEL_W'(r))) begin
        regs_d[r] = rf.i_wr_data;
      end
      if (r == FLAG_IDX) begin
        regs_d[r][3:0] = 4'h0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
`ifdef REG_FILE_BYPASS_EN
      view[r] = regs_d[r];
`else
      view[r] = regs_q[r];
`endif
    end
  end

  // Select-by-match muxes: unmatched (out-of-range) selects read as 0.
  always_comb begin
    rf.o_rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rf.i_rd_sel[k*SEL_W +: SEL_W] == SEL_W'(r)) rf.o_rd_data[k*DATA_W +: DATA_W] = view[r];
      end
    end
  end

  always_comb begin
    rf.o_rdp_data = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (rf.i_rdp_sel == PSEL_W'(p)) rf.o_rdp_data = {view[2*p], view[2*p+1]};
    end
  end

  assign rf.o_idu_result = idu_result;
  assign rf.o_flags      = view[FLAG_IDX][DATA_W-1 -: 4];
endmodule

// File: tb/tb_gb_reg_file_multi.sv
// Randomized + directed scoreboard bench for gb_reg_file_multi (default map B C D E H L A F).
// Driver pushes expected read values per cycle; monitor pops and compares on the falling edge.
module tb_gb_reg_file_multi;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int NRD = 2;
  localparam int B = 0, C = 1, D = 2, E = 3, H = 4, L = 5, A = 6, F = 7;
  localparam int BC = 0, DE = 1, HL = 2, AF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gb_reg_file_multi_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) rf_if ();

  gb_reg_file_multi #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .FLAG_IDX(7)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rf      (rf_if)
  );

  typedef struct {
    bit rst;
    bit we; int ws; int wd;
    bit pe; int ps; int pd;
    bit ie; bit id; int is;
    int r0; int r1; int rp;
  } op_t;

  typedef struct {
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic [15:0] rdp;
    logic [15:0] idu;
    bit          ie;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  logic [7:0] m [8];
  int n_chk = 0;
  int n_fail = 0;

  function automatic op_t idle();
    op_t o;
    o = '{default: 0};
    o.r1 = 1;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o = idle();
    o.we = ($urandom_range(0, 2) == 0);
    o.ws = $urandom_range(0, 7);
    o.wd = $urandom_range(0, 255);
    o.pe = ($urandom_range(0, 2) == 0);
    o.ps = $urandom_range(0, 3);
    o.pd = $urandom_range(0, 65535);
    o.ie = ($urandom_range(0, 2) == 0);
    o.id = $urandom_range(0, 1);
    o.is = $urandom_range(0, 3);
    o.r0 = $urandom_range(0, 7);
    o.r1 = $urandom_range(0, 7);
    o.rp = $urandom_range(0, 3);
    return o;
  endfunction

  // Apply one request after the rising edge; expectations come from the byte-array model.
  task automatic issue(input op_t o);
    exp_t e;
    logic [7:0] post [8];
    logic [7:0] view [8];
    int v;
    @(posedge clk);
    #1;
    rst_n              = o.rst ? 1'b0 : 1'b1;
    rf_if.i_wr_en      = o.we;
    rf_if.i_wr_sel     = 3'(o.ws);
    rf_if.i_wr_data    = 8'(o.wd);
    rf_if.i_wrp_en     = o.pe;
    rf_if.i_wrp_sel    = 2'(o.ps);
    rf_if.i_wrp_data   = 16'(o.pd);
    rf_if.i_idu_en     = o.ie;
    rf_if.i_idu_dec    = o.id;
    rf_if.i_idu_sel    = 2'(o.is);
    rf_if.i_rd_sel     = {3'(o.r1), 3'(o.r0)};
    rf_if.i_rdp_sel    = 2'(o.rp);
    e.ie  = o.ie && !o.rst;
    e.idu = '0;
    if (o.rst) begin
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
    end
    post = m;
    if (!o.rst) begin
      v = int'(m[2*o.is]) * 256 + int'(m[2*o.is+1]);
      v = o.id ? (v + 65535) % 65536 : (v + 1) % 65536;
      e.idu = 16'(v);
      if (o.ie) begin
        post[2*o.is]   = 8'(v / 256);
        post[2*o.is+1] = 8'(v % 256);
      end
      if (o.pe) begin
        post[2*o.ps]   = 8'(o.pd / 256);
        post[2*o.ps+1] = 8'(o.pd % 256);
      end
      if (o.we) post[o.ws] = 8'(o.wd);
      post[F] = post[F] & 8'hF0;
    end
`ifdef REG_FILE_BYPASS_EN
    view = post;
`else
    view = m;
`endif
    e.rd0   = view[o.r0];
    e.rd1   = view[o.r1];
    e.rdp   = {view[2*o.rp], view[2*o.rp+1]};
    e.flags = view[F][7:4];
    sb.push_back(e);
    m = post;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd0", 16'(rf_if.o_rd_data[7:0]), 16'(e.rd0));
        chk("rd1", 16'(rf_if.o_rd_data[15:8]), 16'(e.rd1));
        chk("rdp", rf_if.o_rdp_data, e.rdp);
        chk("flags", 16'(rf_if.o_flags), 16'(e.flags));
        if (e.ie) chk("idu_result", rf_if.o_idu_result, e.idu);
      end
    end
  end

  initial begin : stim
    op_t o;
    rf_if.i_wr_en = 1'b0; rf_if.i_wr_sel = '0; rf_if.i_wr_data = '0;
    rf_if.i_wrp_en = 1'b0; rf_if.i_wrp_sel = '0; rf_if.i_wrp_data = '0;
    rf_if.i_idu_en = 1'b0; rf_if.i_idu_dec = 1'b0; rf_if.i_idu_sel = '0;
    rf_if.i_rd_sel = '0; rf_if.i_rdp_sel = '0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;

    o = idle(); o.rst = 1; issue(o);
    // Fill everything with 0xFF, observe it, then pulse reset.
    for (int p = 0; p < 4; p++) begin
      o = idle(); o.pe = 1; o.ps = p; o.pd = 'hFFFF; o.r0 = 2*p; o.rp = p; issue(o);
    end
    o = idle(); o.r0 = A; o.r1 = F; o.rp = AF; issue(o);
    o = idle(); o.rst = 1; o.r0 = A; o.r1 = H; o.rp = HL; issue(o);
    // Byte then pair write.
    o = idle(); o.we = 1; o.ws = H; o.wd = 'h12; o.r0 = H; issue(o);
    o = idle(); o.pe = 1; o.ps = DE; o.pd = 'hBEEF; o.r0 = H; o.r1 = E; o.rp = DE; issue(o);
    o = idle(); o.r0 = H; o.r1 = E; o.rp = DE; issue(o);
    // IDU wrap both ways on HL.
    o = idle(); o.pe = 1; o.ps = HL; o.pd = 'hFFFF; o.rp = HL; issue(o);
    o = idle(); o.ie = 1; o.is = HL; o.rp = HL; issue(o);
    o = idle(); o.ie = 1; o.id = 1; o.is = HL; o.rp = HL; issue(o);
    o = idle(); o.rp = HL; o.r0 = H; o.r1 = L; issue(o);
    // Three-way collision on BC.
    o = idle(); o.we = 1; o.ws = C; o.wd = 'h55; o.pe = 1; o.ps = BC; o.pd = 'hAABB;
    o.ie = 1; o.is = BC; o.rp = BC; issue(o);
    o = idle(); o.rp = BC; o.r0 = B; o.r1 = C; issue(o);
    // Flag nibble masking via pair write, byte write and IDU.
    o = idle(); o.pe = 1; o.ps = AF; o.pd = 'h12FF; o.rp = AF; issue(o);
    o = idle(); o.r0 = A; o.r1 = F; o.rp = AF; issue(o);
    o = idle(); o.we = 1; o.ws = F; o.wd = 'h0F; o.r1 = F; issue(o);
    o = idle(); o.r1 = F; o.rp = AF; issue(o);
    o = idle(); o.pe = 1; o.ps = AF; o.pd = 'h34F0; issue(o);
    o = idle(); o.ie = 1; o.is = AF; o.rp = AF; issue(o);
    o = idle(); o.rp = AF; o.r1 = F; issue(o);
    // Same-cycle write and read of A.
    o = idle(); o.we = 1; o.ws = A; o.wd = 'h7E; o.r0 = A; o.rp = AF; issue(o);
    o = idle(); o.r0 = A; issue(o);
    // Disjoint three-source update.
    o = idle(); o.we = 1; o.ws = A; o.wd = 'h5A; o.pe = 1; o.ps = DE; o.pd = 'h1357;
    o.ie = 1; o.id = 1; o.is = HL; o.rp = HL; issue(o);
    o = idle(); o.r0 = A; o.r1 = D; o.rp = DE; issue(o);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        o = idle(); o.rst = 1; o.r0 = $urandom_range(0, 7); o.rp = $urandom_range(0, 3);
      end else begin
        o = rnd_op();
      end
      issue(o);
    end

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
